// File: rtl/mem_pkg.sv
// Shared definitions for the instruction-cache refill responder.
package mem_pkg;

  // Default byte-address width shared with the cache (1 MB space).
  localparam int DEF_ADDR_W = 20;

  // Word delivered to the cache when a refill times out (RISC-V NOP).
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  // Refill controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    DELIVER = 3'd2,
    HOLD    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Number of external beats needed to assemble one 32-bit word.
  function automatic int beats_of(input int mem_dw);
    return 32 / mem_dw;
  endfunction

endpackage

// File: rtl/icache_refill_beat_assembler.sv
// Collects MEM_DW-wide memory beats into a 32-bit little-endian word.
// Tracks the current beat index and flags the last beat of the word.
module beat_assembler
  import mem_pkg::*;
#(
  parameter  int MEM_DW = 16,
  localparam int BEATS  = beats_of(MEM_DW),
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_nop,
  input  logic              beat_valid,
  input  logic [MEM_DW-1:0] beat_data,
  output logic [31:0]       word,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              last_beat
);

  logic [31:0]      word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign last_beat = (idx_q == IDX_W'(BEATS - 1));

  // Next word/index: clear on capture, NOP on timeout, else insert the beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load_nop) begin
      word_d = NOP_INSN;
      idx_d  = '0;
    end else if (beat_valid) begin
      for (int b = 0; b < BEATS; b++) begin
        if (idx_q == IDX_W'(b)) word_d[b*MEM_DW +: MEM_DW] = beat_data;
      end
      idx_d = last_beat ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Word buffer and beat counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word     = word_q;
  assign beat_idx = idx_q;

endmodule

// File: rtl/icache_refill.sv
// Memory-side responder for the instruction-cache miss handshake.
// Captures a miss address, fetches the 32-bit word beat by beat over the
// narrow req/ack bus and hands it back with a one-cycle fetch strobe.
// Optional per-beat timeout with NOP delivery: define ICACHE_REFILL_TIMEOUT_EN.
module icache_refill
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_DW  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              fetch,
  output logic [31:0]       write_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic              busy
`ifdef ICACHE_REFILL_TIMEOUT_EN
  ,
  output logic              refill_err
`endif
);

  localparam int BEATS   = beats_of(MEM_DW);
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SH = $clog2(MEM_DW / 8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  beat_idx;
  logic              last_beat;
  logic              capture;
  logic              beat_valid;
  logic              load_nop;
  logic              in_req;

  // The word-aligned base drops the two byte-offset bits of the miss address.
  logic unused_bits;
  assign unused_bits = ^{miss_addr[1:0], 32'(TIMEOUT)};

  assign in_req = (state_q == REQ) || (state_q == DRAIN);

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              timeout;

  // The current beat has been requested TIMEOUT cycles without an ack.
  assign timeout = in_req && !mem_ack && (wait_q == WAIT_W'(TIMEOUT - 1));
`endif

  // Refill FSM: next state, base capture and beat bookkeeping.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    capture    = 1'b0;
    beat_valid = 1'b0;
    load_nop   = 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cache_miss) begin
          capture = 1'b1;
          base_d  = {miss_addr[ADDR_W-1:2], 2'b00};
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // The acked beat always completes, even if the cache gave up.
          beat_valid = 1'b1;
          if (!cache_miss)    state_d = IDLE;
          else if (last_beat) state_d = DELIVER;
        end else if (!cache_miss) begin
          state_d = DRAIN;
        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
        else if (timeout) begin
          load_nop = 1'b1;
          err_d    = 1'b1;
          state_d  = DELIVER;
        end
`endif
      end
      DELIVER: state_d = HOLD;
      // Cooldown: the cache re-reads its RAM, so a held miss is not re-captured.
      HOLD:    state_d = IDLE;
      DRAIN: begin
        if (mem_ack) state_d = IDLE;
`ifdef ICACHE_REFILL_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured base address registers.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

`ifdef ICACHE_REFILL_TIMEOUT_EN
  // Per-beat wait counter: clears on ack and on every state change.
  always_comb begin
    wait_d = '0;
    if (in_req && !mem_ack && (state_d == state_q)) wait_d = wait_q + WAIT_W'(1);
  end

  // Wait counter and one-cycle error pulse registers.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign refill_err = err_q;
`endif

  beat_assembler #(
    .MEM_DW(MEM_DW)
  ) u_beat_assembler (
    .clk       (CLK),
    .rst_n     (resetn),
    .clear     (capture),
    .load_nop  (load_nop),
    .beat_valid(beat_valid),
    .beat_data (mem_rdata),
    .word      (write_data),
    .beat_idx  (beat_idx),
    .last_beat (last_beat)
  );

  assign busy     = (state_q != IDLE);
  assign fetch    = (state_q == DELIVER);
  assign mem_req  = in_req;
  assign mem_addr = in_req ? base_q + (ADDR_W'(beat_idx) << BYTE_SH) : '0;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill (ADDR_W=20, MEM_DW=16, TIMEOUT=4).
// Build with ICACHE_REFILL_TIMEOUT_EN defined to also exercise the timeout path.
module tb_icache_refill;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        cache_miss;
  logic [19:0] miss_addr;
  logic        fetch;
  logic [31:0] write_data;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        busy;
`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic        refill_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  icache_refill #(
    .ADDR_W (20),
    .MEM_DW (16),
    .TIMEOUT(4)
  ) dut (
    .CLK       (CLK),
    .resetn    (resetn),
    .cache_miss(cache_miss),
    .miss_addr (miss_addr),
    .fetch     (fetch),
    .write_data(write_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef ICACHE_REFILL_TIMEOUT_EN
    ,
    .refill_err(refill_err)
`endif
  );

  typedef struct {
    logic [19:0] addr;
    int          w0;
    int          w1;
    logic [31:0] word;
    int          exp_fetch;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One refill with w0/w1 wait states on beats 0/1; the bench acts as memory.
  // Starts at the cycle the miss is presented (cycle 0).
  task automatic do_refill(input string tag, input logic [19:0] addr, input int w0, input int w1,
                           input logic [31:0] word, input int exp_fetch,
                           input bit keep_miss, input logic [19:0] next_addr);
    logic [19:0] base;
    logic [31:0] got_word;
    int beat, waited, fetch_cyc;
    base      = {addr[19:2], 2'b00};
    beat      = 0;
    waited    = 0;
    fetch_cyc = -1;
    got_word  = '0;
    cache_miss = 1'b1;
    miss_addr  = addr;
    mem_ack    = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      mem_ack = 1'b0;
      if (fetch) begin
        fetch_cyc = cyc;
        got_word  = write_data;
`ifdef ICACHE_REFILL_TIMEOUT_EN
        check({tag, "_err"}, 32'(refill_err), 32'd0);
`endif
        if (!keep_miss) cache_miss = 1'b0;
        break;
      end
      if (mem_req) begin
        check({tag, "_addr"}, 32'(mem_addr), 32'(base + 20'(2 * beat)));
        if (beat < 2 && waited == ((beat == 0) ? w0 : w1)) begin
          mem_ack   = 1'b1;
          mem_rdata = word[16*beat +: 16];
          beat++;
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
    check({tag, "_fetch_cycle"}, 32'(fetch_cyc), 32'(exp_fetch));
    check({tag, "_word"}, got_word, word);
    tick();
    check({tag, "_hold_fetch"}, 32'(fetch), 32'd0);
    check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    if (keep_miss) miss_addr = next_addr;
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{20'h00404, 0, 0, 32'h00100113, 3};
    vecs[1] = '{20'h00404, 3, 3, 32'h00100113, 9};
    vecs[2] = '{20'h12346, 1, 0, 32'hDEADBEEF, 4};
    vecs[3] = '{20'hFFFFE, 0, 2, 32'hCAFEF00D, 5};

    resetn     = 1'b0;
    cache_miss = 1'b0;
    miss_addr  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    check("rst_fetch", 32'(fetch), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
`ifdef ICACHE_REFILL_TIMEOUT_EN
    check("rst_err", 32'(refill_err), 32'd0);
`endif
    resetn = 1'b1;
    tick();

    // Table-driven refills.
    for (int i = 0; i < 4; i++)
      do_refill($sformatf("vec%0d", i), vecs[i].addr, vecs[i].w0, vecs[i].w1,
                vecs[i].word, vecs[i].exp_fetch, 1'b0, '0);

    // Miss held through fetch and HOLD; the new address is captured only from IDLE.
    do_refill("keep", 20'h00800, 0, 1, 32'h01234567, 4, 1'b1, 20'hFFFFC);
    do_refill("after_hold", 20'hFFFFC, 0, 0, 32'h89ABCDEF, 3, 1'b0, '0);

    // Miss dropped during the beat-0 wait: drain the beat, no fetch, no beat 1.
    cache_miss = 1'b1;
    miss_addr  = 20'h03000;
    tick();
    check("abort_req", 32'(mem_req), 32'd1);
    check("abort_addr", 32'(mem_addr), 32'h03000);
    cache_miss = 1'b0;
    tick();
    check("drain_req", 32'(mem_req), 32'd1);
    check("drain_addr", 32'(mem_addr), 32'h03000);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_fetch", 32'(fetch), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBAD0;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_after_req", 32'(mem_req), 32'd0);
      check("drain_after_fetch", 32'(fetch), 32'd0);
      check("drain_after_busy", 32'(busy), 32'd0);
      tick();
    end

    // Drop and ack in the same cycle on the last beat: no fetch.
    cache_miss = 1'b1;
    miss_addr  = 20'h04000;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    check("dropack_addr", 32'(mem_addr), 32'h04002);
    mem_rdata  = 16'h2222;
    cache_miss = 1'b0;
    tick();
    mem_ack = 1'b0;
    check("dropack_fetch", 32'(fetch), 32'd0);
    check("dropack_busy", 32'(busy), 32'd0);
    tick();
    check("dropack_fetch2", 32'(fetch), 32'd0);

    // Reset mid-beat 1, then a full refill.
    cache_miss = 1'b1;
    miss_addr  = 20'h0A008;
    tick();
    check("midrst_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("midrst_b1_addr", 32'(mem_addr), 32'h0A00A);
    resetn = 1'b0;
    tick();
    resetn     = 1'b1;
    cache_miss = 1'b0;
    check("midrst_fetch", 32'(fetch), 32'd0);
    check("midrst_req0", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wdata", write_data, 32'd0);
    check("midrst_maddr", 32'(mem_addr), 32'd0);
    tick();
    do_refill("postrst", 20'h0A008, 1, 1, 32'h55667788, 5, 1'b0, '0);

    // Randomized refills against the latency/ordering model.
    for (int i = 0; i < 16; i++) begin
      logic [19:0] a;
      logic [31:0] w;
      int          w0, w1;
      a  = 20'($urandom());
      w  = $urandom();
      w0 = $urandom_range(3, 0);
      w1 = $urandom_range(3, 0);
      do_refill($sformatf("rnd%0d", i), a, w0, w1, w, 1 + (w0 + 1) + (w1 + 1), 1'b0, '0);
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    // Memory never acks: one error pulse, NOP delivered, back to IDLE after HOLD.
    begin
      int fc, errs, reqs;
      fc   = -1;
      errs = 0;
      reqs = 0;
      cache_miss = 1'b1;
      miss_addr  = 20'h05000;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        tick();
        if (refill_err) errs++;
        if (mem_req) reqs++;
        if (fetch) begin
          fc = cyc;
          check("to_word", write_data, 32'h00000013);
          check("to_err_with_fetch", 32'(refill_err), 32'd1);
          cache_miss = 1'b0;
        end
      end
      check("to_fetch_cycle", 32'(fc), 32'd5);
      check("to_err_pulses", 32'(errs), 32'd1);
      check("to_req_cycles", 32'(reqs), 32'd4);
      check("to_idle", 32'(busy), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
